// File: rtl/mm_seq_if.sv
// Command/feed interface between the systolic-array feeder (mm_seq) and its
// surroundings: start/hold come in, BRAM read strobes and array side-band
// markers go out.
interface mm_seq_if #(
    parameter int M  = 4,
    parameter int N1 = 4,
    parameter int N2 = 4
);
    localparam int A_W = (M * M / N1 > 1) ? $clog2(M * M / N1) : 1;
    localparam int B_W = (M * M / N2 > 1) ? $clog2(M * M / N2) : 1;

    logic           start;
    logic           hold;
    logic           rd_en;
    logic [A_W-1:0] rd_addr_A;
    logic [B_W-1:0] rd_addr_B;
    logic           feed_valid;
    logic           first_k;
    logic           last_k;
    logic           enable_row_count_A;
    logic           busy;
    logic           done;

    // Sequencer side
    modport slave (
        input  start,
        input  hold,
        output rd_en,
        output rd_addr_A,
        output rd_addr_B,
        output feed_valid,
        output first_k,
        output last_k,
        output enable_row_count_A,
        output busy,
        output done
    );

    // Controller / environment side
    modport master (
        output start,
        output hold,
        input  rd_en,
        input  rd_addr_A,
        input  rd_addr_B,
        input  feed_valid,
        input  first_k,
        input  last_k,
        input  enable_row_count_A,
        input  busy,
        input  done
    );
endinterface

// File: rtl/mm_seq.sv
// Matrix-multiply feed sequencer. Walks the A/B BRAM banks patch by patch
// (B slice inner, A slice outer), streaming k = 0..M-1 for each patch, then
// flushes the array for DRAIN_CYC cycles and pulses done.
module mm_seq #(
    parameter int M         = 4,
    parameter int N1        = 4,
    parameter int N2        = 4,
    parameter int DRAIN_CYC = N1 + N2 + 1
) (
    input  logic     clk,
    input  logic     rst,
    mm_seq_if.slave  bus
);
    localparam int SA_CNT = M / N1;
    localparam int SB_CNT = M / N2;
    // Counters keep at least one bit even when a slice count collapses to 1.
    localparam int K_W  = (M > 1)      ? $clog2(M)      : 1;
    localparam int SA_W = (SA_CNT > 1) ? $clog2(SA_CNT) : 1;
    localparam int SB_W = (SB_CNT > 1) ? $clog2(SB_CNT) : 1;
    localparam int D_W  = $clog2(DRAIN_CYC + 1);
    localparam int A_W  = (M * M / N1 > 1) ? $clog2(M * M / N1) : 1;
    localparam int B_W  = (M * M / N2 > 1) ? $clog2(M * M / N2) : 1;

    localparam logic [K_W-1:0]  K_LAST  = K_W'(M - 1);
    localparam logic [SA_W-1:0] SA_LAST = SA_W'(SA_CNT - 1);
    localparam logic [SB_W-1:0] SB_LAST = SB_W'(SB_CNT - 1);
    localparam logic [D_W-1:0]  D_LAST  = D_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [K_W-1:0]  k_reg, k_next;
    logic [SA_W-1:0] sa_reg, sa_next;
    logic [SB_W-1:0] sb_reg, sb_next;
    logic [D_W-1:0]  drain_reg, drain_next;
    logic            feed_valid_reg, feed_valid_next;
    logic            first_k_reg, first_k_next;
    logic            last_k_reg, last_k_next;
    logic            row_done_reg, row_done_next;
    logic            rd_en;
    logic            k_last;
    logic            sb_last;
    logic            sa_last;

    // State, counters and array side-band markers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            k_reg          <= '0;
            sa_reg         <= '0;
            sb_reg         <= '0;
            drain_reg      <= '0;
            feed_valid_reg <= 1'b0;
            first_k_reg    <= 1'b0;
            last_k_reg     <= 1'b0;
            row_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            sa_reg         <= sa_next;
            sb_reg         <= sb_next;
            drain_reg      <= drain_next;
            feed_valid_reg <= feed_valid_next;
            first_k_reg    <= first_k_next;
            last_k_reg     <= last_k_next;
            row_done_reg   <= row_done_next;
        end
    end

    // Next-state, counter advance and combinational read strobe
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        drain_next = drain_reg;

        // Feeding only advances when the output path is not pushing back.
        rd_en   = (state_reg == S_FEED) && !bus.hold;
        k_last  = (k_reg == K_LAST);
        sb_last = (sb_reg == SB_LAST);
        sa_last = (sa_reg == SA_LAST);

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FEED;
                    k_next     = '0;
                    sa_next    = '0;
                    sb_next    = '0;
                end
            end
            S_FEED: begin
                if (rd_en) begin
                    if (k_last) begin
                        k_next = '0;
                        if (sb_last) begin
                            sb_next = '0;
                            if (sa_last) begin
                                // Last beat of the last patch: flush the array.
                                sa_next    = '0;
                                drain_next = '0;
                                state_next = S_DRAIN;
                            end else begin
                                sa_next = sa_reg + 1'b1;
                            end
                        end else begin
                            sb_next = sb_reg + 1'b1;
                        end
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Fixed-length flush; hold has no effect here.
                if (drain_reg == D_LAST) begin
                    drain_next = '0;
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Markers travel with the BRAM data, one cycle behind the strobe.
        feed_valid_next = rd_en;
        first_k_next    = rd_en && (k_reg == '0);
        last_k_next     = rd_en && k_last;
        row_done_next   = rd_en && k_last && sb_last;
    end

    assign bus.rd_en              = rd_en;
    assign bus.rd_addr_A          = A_W'(int'(sa_reg) * M + int'(k_reg));
    assign bus.rd_addr_B          = B_W'(int'(sb_reg) * M + int'(k_reg));
    assign bus.feed_valid         = feed_valid_reg;
    assign bus.first_k            = first_k_reg;
    assign bus.last_k             = last_k_reg;
    assign bus.enable_row_count_A = row_done_reg;
    assign bus.busy               = (state_reg == S_FEED) || (state_reg == S_DRAIN);
    assign bus.done               = (state_reg == S_DONE);

endmodule
